// File: rtl/temp_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : temp_sampler
//  Brief    : Block-averages raw SYSMON die-temperature samples and derives a
//             fail-safe over-temperature alarm with hysteresis and a
//             sample-stall watchdog. Feeds the fan controller.
//  Revision : 1.0 - initial release
// ============================================================================
module temp_sampler #(
  parameter int SAMPLE_W       = 16,
  parameter int AVG_LOG2       = 3,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic                clk_in_100,
  input  logic                rst_n_in,
  input  logic                sample_valid_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SAMPLE_W-1:0] alarm_set_in,
  input  logic [SAMPLE_W-1:0] alarm_clear_in,
  output logic [31:0]         avg_temp_out,
  output logic                avg_valid_out,
  output logic                temp_alarm_out,
  output logic                stale_out
);

  // Accumulator is wide enough for a full block of max-code samples.
  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  // Sample counter width; at least one bit so pass-through mode still builds.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  // Watchdog must be able to hold TIMEOUT_CYCLES itself (saturation value).
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_count_last = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [WD_W-1:0]  c_wd_max     = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  c_wd_last    = WD_W'(TIMEOUT_CYCLES - 1);
  // Reset average reads as the hottest possible code.
  localparam logic [31:0]      c_avg_reset  = 32'((64'd1 << SAMPLE_W) - 64'd1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_alarm;
  logic                w_alarm_next;
  logic                r_stale;
  logic                w_stale_next;
  logic                w_avg_load;
  logic                w_acc_clear;

  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_count;
  logic [WD_W-1:0]     r_wdog;
  logic [31:0]         r_avg;
  logic                r_avg_valid;

  logic [ACC_W-1:0]    w_sum;
  logic [SAMPLE_W-1:0] w_avg;
  logic                w_block_done;
  logic                w_timeout;
  logic [SAMPLE_W-1:0] w_eff_clear;
  logic                w_alarm_eval;

  // Sum including the sample arriving this cycle, and its truncated average.
  assign w_sum        = r_acc + ACC_W'(sample_in);
  assign w_avg        = SAMPLE_W'(w_sum >> AVG_LOG2);
  assign w_block_done = sample_valid_in && (r_count == c_count_last);
  // Stale fires on the edge where the idle count would reach the limit;
  // a strobe on that same cycle resets the count instead.
  assign w_timeout    = !sample_valid_in && (r_wdog == c_wd_last);

  // A clear threshold above the set threshold collapses to a single threshold.
  assign w_eff_clear  = (alarm_clear_in < alarm_set_in) ? alarm_clear_in : alarm_set_in;

  // Hysteresis decision for a freshly computed average.
  always_comb begin
    w_alarm_eval = r_alarm;
    if (w_avg >= alarm_set_in) begin
      w_alarm_eval = 1'b1;
    end else if (w_avg < w_eff_clear) begin
      w_alarm_eval = 1'b0;
    end
  end

  // Control state and alarm/stale flag registers.
  always_ff @(posedge clk_in_100 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_FILL;
      r_alarm <= 1'b1;
      r_stale <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_alarm <= w_alarm_next;
      r_stale <= w_stale_next;
    end
  end

  // Next-state, alarm and datapath control decode.
  always_comb begin
    w_state_next = r_state;
    w_alarm_next = r_alarm;
    w_stale_next = r_stale;
    w_avg_load   = 1'b0;
    w_acc_clear  = 1'b0;
    case (r_state)
      ST_FILL, ST_RUN: begin
        if (w_timeout) begin
          // Samples stopped: force the fan on and drop the partial block.
          w_state_next = ST_STALE;
          w_alarm_next = 1'b1;
          w_stale_next = 1'b1;
          w_acc_clear  = 1'b1;
        end else if (w_block_done) begin
          // In FILL the alarm is still 1, so the hold branch keeps it set.
          w_state_next = ST_RUN;
          w_avg_load   = 1'b1;
          w_alarm_next = w_alarm_eval;
        end
      end
      ST_STALE: begin
        if (sample_valid_in) begin
          // First fresh sample restarts a block; in pass-through mode it is
          // also the whole block.
          w_stale_next = 1'b0;
          w_state_next = ST_FILL;
          if (w_block_done) begin
            w_state_next = ST_RUN;
            w_avg_load   = 1'b1;
            w_alarm_next = w_alarm_eval;
          end
        end
      end
      default: begin
        w_state_next = ST_FILL;
        w_alarm_next = 1'b1;
        w_stale_next = 1'b0;
        w_acc_clear  = 1'b1;
      end
    endcase
  end

  // Block accumulator and sample counter; cleared on block end or stale entry.
  always_ff @(posedge clk_in_100 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_acc_clear || w_block_done) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (sample_valid_in) begin
      r_acc   <= w_sum;
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Idle-cycle watchdog, saturating at the timeout value.
  always_ff @(posedge clk_in_100 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wdog <= '0;
    end else if (sample_valid_in) begin
      r_wdog <= '0;
    end else if (r_wdog != c_wd_max) begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

  // Averaged output register and its one-cycle update strobe.
  always_ff @(posedge clk_in_100 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_avg       <= c_avg_reset;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= w_avg_load;
      if (w_avg_load) begin
        r_avg <= 32'(w_avg);
      end
    end
  end

  assign avg_temp_out   = r_avg;
  assign avg_valid_out  = r_avg_valid;
  assign temp_alarm_out = r_alarm;
  assign stale_out      = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_temp_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_temp_sampler
//  Brief    : Self-checking bench for temp_sampler (AVG_LOG2=2, timeout=100)
//             with directed scenarios followed by randomized traffic against
//             a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_temp_sampler;

  localparam int SAMPLE_W = 16;
  localparam int AVG_LOG2 = 2;
  localparam int BLOCK    = 4;
  localparam int TIMEOUT  = 100;

  logic        clk_in_100;
  logic        rst_n_in;
  logic        sample_valid_in;
  logic [15:0] sample_in;
  logic [15:0] alarm_set_in;
  logic [15:0] alarm_clear_in;
  logic [31:0] avg_temp_out;
  logic        avg_valid_out;
  logic        temp_alarm_out;
  logic        stale_out;

  int n_checks;
  int n_fail;

  // Reference model state, kept in plain behavioural terms.
  int unsigned blk_q[$];
  int unsigned m_avg;
  bit          m_valid;
  bit          m_alarm;
  bit          m_stale;
  bit          m_running;   // at least one average seen since reset/stale
  bit          m_is_stale;
  int          m_idle;

  temp_sampler #(
    .SAMPLE_W      (SAMPLE_W),
    .AVG_LOG2      (AVG_LOG2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) u_dut (
    .clk_in_100     (clk_in_100),
    .rst_n_in       (rst_n_in),
    .sample_valid_in(sample_valid_in),
    .sample_in      (sample_in),
    .alarm_set_in   (alarm_set_in),
    .alarm_clear_in (alarm_clear_in),
    .avg_temp_out   (avg_temp_out),
    .avg_valid_out  (avg_valid_out),
    .temp_alarm_out (temp_alarm_out),
    .stale_out      (stale_out)
  );

  initial clk_in_100 = 1'b0;
  always #5 clk_in_100 = ~clk_in_100;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    blk_q.delete();
    m_avg      = 32'hFFFF;
    m_valid    = 1'b0;
    m_alarm    = 1'b1;
    m_stale    = 1'b0;
    m_running  = 1'b0;
    m_is_stale = 1'b0;
    m_idle     = 0;
  endtask

  // One clock edge of the reference behaviour given the inputs at that edge.
  task automatic model_edge(input bit v, input int unsigned s, input int unsigned set_t, input int unsigned clr_t);
    int unsigned sum;
    int unsigned avg;
    int unsigned eff_clr;
    m_valid = 1'b0;
    if (!v) begin
      if (m_idle < TIMEOUT) begin
        m_idle++;
        if (m_idle == TIMEOUT && !m_is_stale) begin
          m_is_stale = 1'b1;
          m_stale    = 1'b1;
          m_alarm    = 1'b1;
          m_running  = 1'b0;
          blk_q.delete();
        end
      end
    end else begin
      m_idle = 0;
      if (m_is_stale) begin
        m_is_stale = 1'b0;
        m_stale    = 1'b0;
      end
      blk_q.push_back(s);
      if (blk_q.size() == BLOCK) begin
        sum = 0;
        foreach (blk_q[i]) sum += blk_q[i];
        avg     = sum / BLOCK;
        eff_clr = (clr_t < set_t) ? clr_t : set_t;
        m_avg   = avg;
        m_valid = 1'b1;
        if (avg >= set_t)        m_alarm = 1'b1;
        else if (avg < eff_clr)  m_alarm = (m_running) ? 1'b0 : 1'b0;
        m_running = 1'b1;
        blk_q.delete();
      end
    end
  endtask

  task automatic compare_all();
    check_value("avg_temp",   avg_temp_out,          m_avg);
    check_value("avg_valid",  32'(avg_valid_out),    32'(m_valid));
    check_value("temp_alarm", 32'(temp_alarm_out),   32'(m_alarm));
    check_value("stale",      32'(stale_out),        32'(m_stale));
  endtask

  // Apply inputs for one clock, advance model, compare after the edge.
  task automatic cycle(input bit v, input logic [15:0] s);
    sample_valid_in = v;
    sample_in       = s;
    @(posedge clk_in_100);
    #1;
    model_edge(v, s, alarm_set_in, alarm_clear_in);
    compare_all();
    sample_valid_in = 1'b0;
  endtask

  task automatic block_of(input logic [15:0] s);
    for (int i = 0; i < BLOCK; i++) cycle(1'b1, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n_in        = 1'b0;
    sample_valid_in = 1'b0;
    sample_in       = '0;
    alarm_set_in    = 16'd45000;
    alarm_clear_in  = 16'd43000;
    model_reset();
    repeat (3) @(posedge clk_in_100);
    #3;
    rst_n_in = 1'b1;

    // Reset state before any sample.
    check_value("rst_avg",   avg_temp_out, 32'h0000FFFF);
    check_value("rst_valid", 32'(avg_valid_out), 32'd0);
    check_value("rst_alarm", 32'(temp_alarm_out), 32'd1);
    check_value("rst_stale", 32'(stale_out), 32'd0);

    // First block: truncating average with 1-cycle latency.
    cycle(1'b1, 16'd40000);
    cycle(1'b1, 16'd40001);
    cycle(1'b1, 16'd40002);
    check_value("pre_avg", avg_temp_out, 32'h0000FFFF);
    check_value("pre_alarm", 32'(temp_alarm_out), 32'd1);
    cycle(1'b1, 16'd40003);
    check_value("first_avg", avg_temp_out, 32'd40001);
    check_value("first_valid", 32'(avg_valid_out), 32'd1);
    cycle(1'b0, 16'd0);
    check_value("valid_1cyc", 32'(avg_valid_out), 32'd0);

    // Hysteresis: set=45000, clear=43000.
    block_of(16'd46000); check_value("hyst_46000", 32'(temp_alarm_out), 32'd1);
    block_of(16'd44000); check_value("hyst_44000", 32'(temp_alarm_out), 32'd1);
    block_of(16'd42900); check_value("hyst_42900", 32'(temp_alarm_out), 32'd0);
    block_of(16'd44000); check_value("hyst_44000b", 32'(temp_alarm_out), 32'd0);

    // Clear above set collapses to a single threshold.
    alarm_set_in   = 16'd43000;
    alarm_clear_in = 16'd45000;
    block_of(16'd44000); check_value("single_44000", 32'(temp_alarm_out), 32'd1);
    block_of(16'd42999); check_value("single_42999", 32'(temp_alarm_out), 32'd0);
    alarm_set_in   = 16'd45000;
    alarm_clear_in = 16'd43000;

    // Stall after two samples of a block.
    cycle(1'b1, 16'd50000);
    cycle(1'b1, 16'd50000);
    idle(TIMEOUT - 1);
    check_value("stale_not_yet", 32'(stale_out), 32'd0);
    idle(1);
    check_value("stale_set", 32'(stale_out), 32'd1);
    check_value("stale_alarm", 32'(temp_alarm_out), 32'd1);
    idle(5);
    cycle(1'b1, 16'd30000);
    check_value("stale_clear", 32'(stale_out), 32'd0);
    cycle(1'b1, 16'd30000);
    cycle(1'b1, 16'd30000);
    cycle(1'b1, 16'd30000);
    check_value("recover_avg", avg_temp_out, 32'd30000);
    check_value("recover_alarm", 32'(temp_alarm_out), 32'd0);

    // Strobe exactly on the cycle the watchdog would reach the limit.
    idle(TIMEOUT - 1);
    cycle(1'b1, 16'd30000);
    check_value("wd_race_stale", 32'(stale_out), 32'd0);
    block_of(16'd30000);

    // Full-scale block must not overflow.
    cycle(1'b1, 16'd30000);
    cycle(1'b1, 16'd30000);
    cycle(1'b1, 16'd30000);
    block_of(16'hFFFF);
    cycle(1'b1, 16'hFFFF);
    check_value("fullscale_avg", avg_temp_out, 32'h0000FFFF);

    // Asynchronous reset mid-block discards the partial sum.
    cycle(1'b1, 16'd5000);
    cycle(1'b1, 16'd5000);
    cycle(1'b1, 16'd5000);
    #2 rst_n_in = 1'b0;
    #1;
    check_value("arst_avg",   avg_temp_out, 32'h0000FFFF);
    check_value("arst_valid", 32'(avg_valid_out), 32'd0);
    check_value("arst_alarm", 32'(temp_alarm_out), 32'd1);
    check_value("arst_stale", 32'(stale_out), 32'd0);
    model_reset();
    #2 rst_n_in = 1'b1;
    block_of(16'd1000);
    check_value("arst_next_avg", avg_temp_out, 32'd1000);

    // Randomized traffic around the thresholds, with occasional stalls and
    // threshold changes.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        idle($urandom_range(80, 130));
      end else begin
        if ($urandom_range(0, 49) == 0) begin
          alarm_set_in   = 16'($urandom_range(42000, 46000));
          alarm_clear_in = 16'($urandom_range(40000, 47000));
        end
        if ($urandom_range(0, 2) == 0)
          cycle(1'b1, 16'($urandom_range(39000, 48000)));
        else if ($urandom_range(0, 29) == 0)
          cycle(1'b1, 16'hFFFF);
        else
          cycle(1'b0, 16'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time guard so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
